// File: rtl/shift_reg_universal.sv
// Universal shift register: lsr/lsl/ror/asr, serial in/out, parallel load,
// single-step shift and a counted burst engine with busy/done handshake.
// Ports: clk, areset (async, active-high), load/data (parallel load),
//   ena/mode/ser_in (single step), start/shamt (burst), q, ser_out,
//   busy, done; parity (=^q) only when SHREG_PARITY_EN is defined.
module shift_reg_universal #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             ena,
    input  logic [1:0]       mode,
    input  logic             ser_in,
    input  logic             start,
    input  logic [CNT_W-1:0] shamt,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
`ifdef SHREG_PARITY_EN
    ,
    output logic             parity
`endif
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_mode;
    logic [1:0]       w_mode_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [1:0]       w_eff_mode;

    function automatic logic [WIDTH-1:0] f_shift(
        input logic [WIDTH-1:0] v,
        input logic [1:0]       m,
        input logic             s
    );
        logic [WIDTH-1:0] res;
        unique case (m)
            2'b00:   res = {s, v[WIDTH-1:1]};
            2'b01:   res = {v[WIDTH-2:0], s};
            2'b10:   res = {v[0], v[WIDTH-1:1]};
            default: res = {v[WIDTH-1], v[WIDTH-1:1]};
        endcase
        return res;
    endfunction

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_mode  <= 2'b00;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Priority: load > burst shift > start > ena > hold.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_done_nxt  = 1'b0;
        if (load) begin
            w_q_nxt     = data;
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else if (r_state == SHIFT) begin
            w_q_nxt   = f_shift(r_q, r_mode, ser_in);
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
            end
        end else if (start) begin
            if (shamt != '0) begin
                w_state_nxt = SHIFT;
                w_cnt_nxt   = shamt;
                w_mode_nxt  = mode;
            end else begin
                w_done_nxt = 1'b1;
            end
        end else if (ena) begin
            w_q_nxt = f_shift(r_q, mode, ser_in);
        end
    end

    // While a burst runs the latched mode decides which end shifts out.
    assign w_eff_mode = (r_state == SHIFT) ? r_mode : mode;

    assign q       = r_q;
    assign busy    = (r_state == SHIFT);
    assign done    = r_done;
    assign ser_out = (w_eff_mode == 2'b01) ? r_q[WIDTH-1] : r_q[0];

`ifdef SHREG_PARITY_EN
    assign parity = ^r_q;
`endif

endmodule

// File: tb/tb_shift_reg_universal.sv
// Directed self-checking bench for shift_reg_universal (WIDTH=8, CNT_W=4).
// Drives inputs #1 after the rising edge and samples outputs there too.
module tb_shift_reg_universal;

    logic       clk;
    logic       areset;
    logic       load;
    logic [7:0] data;
    logic       ena;
    logic [1:0] mode;
    logic       ser_in;
    logic       start;
    logic [3:0] shamt;
    logic [7:0] q;
    logic       ser_out;
    logic       busy;
    logic       done;
`ifdef SHREG_PARITY_EN
    logic       parity;
`endif

    int total;
    int bad;

    shift_reg_universal #(.WIDTH(8), .CNT_W(4)) dut (
        .clk     (clk),
        .areset  (areset),
        .load    (load),
        .data    (data),
        .ena     (ena),
        .mode    (mode),
        .ser_in  (ser_in),
        .start   (start),
        .shamt   (shamt),
        .q       (q),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
`ifdef SHREG_PARITY_EN
        ,
        .parity  (parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input logic [7:0] eq,
                        input logic eb, input logic ed);
        chk({tag, ".q"}, 32'(q), 32'(eq));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        areset = 1'b1;
        load   = 1'b0;
        data   = 8'h00;
        ena    = 1'b0;
        mode   = 2'b00;
        ser_in = 1'b0;
        start  = 1'b0;
        shamt  = 4'd0;
        step();
        step();
        chk3("rst", 8'h00, 1'b0, 1'b0);
        chk("rst.ser_out", 32'(ser_out), 32'd0);
`ifdef SHREG_PARITY_EN
        chk("rst.parity", 32'(parity), 32'd0);
`endif
        areset = 1'b0;
        step();

        // 1: single-step lsr with fill 1
        load = 1'b1; data = 8'hA5;
        step();
        load = 1'b0;
        chk("t1.load", 32'(q), 32'hA5);
        ena = 1'b1; mode = 2'b00; ser_in = 1'b1;
        step();
        ena = 1'b0;
        chk3("t1.lsr", 8'hD2, 1'b0, 1'b0);
        chk("t1.ser_out", 32'(ser_out), 32'd0);

        // 2: ror burst of 3
        load = 1'b1; data = 8'h81;
        step();
        load = 1'b0;
        mode = 2'b10; start = 1'b1; shamt = 4'd3;
        step();
        start = 1'b0;
        chk3("t2.k", 8'h81, 1'b1, 1'b0);
        step();
        chk3("t2.s1", 8'hC0, 1'b1, 1'b0);
        step();
        chk3("t2.s2", 8'h60, 1'b1, 1'b0);
        step();
        chk3("t2.s3", 8'h30, 1'b0, 1'b1);
        step();
        chk3("t2.after", 8'h30, 1'b0, 1'b0);

        // 3: asr burst of 2, mode toggled mid-burst
        load = 1'b1; data = 8'h90;
        step();
        load = 1'b0;
        mode = 2'b11; start = 1'b1; shamt = 4'd2;
        step();
        start = 1'b0; mode = 2'b01;
        chk("t3.ser_out", 32'(ser_out), 32'd0);
        step();
        mode = 2'b10;
        chk3("t3.s1", 8'hC8, 1'b1, 1'b0);
        step();
        chk3("t3.s2", 8'hE4, 1'b0, 1'b1);
        step();
        chk3("t3.after", 8'hE4, 1'b0, 1'b0);

        // 4: zero-length burst, then start while busy
        start = 1'b1; shamt = 4'd0;
        step();
        start = 1'b0;
        chk3("t4.z", 8'hE4, 1'b0, 1'b1);
        step();
        chk3("t4.z2", 8'hE4, 1'b0, 1'b0);
        mode = 2'b10; start = 1'b1; shamt = 4'd2;
        step();
        shamt = 4'd0;
        chk3("t4.k", 8'hE4, 1'b1, 1'b0);
        step();
        start = 1'b0;
        chk3("t4.s1", 8'h72, 1'b1, 1'b0);
        step();
        chk3("t4.s2", 8'h39, 1'b0, 1'b1);
        step();
        chk3("t4.no2nd", 8'h39, 1'b0, 1'b0);

        // 5: load aborts an lsl burst
        load = 1'b1; data = 8'hFF;
        step();
        load = 1'b0;
        mode = 2'b01; ser_in = 1'b0; start = 1'b1; shamt = 4'd5;
        step();
        start = 1'b0;
        step();
        chk3("t5.s1", 8'hFE, 1'b1, 1'b0);
        step();
        chk3("t5.s2", 8'hFC, 1'b1, 1'b0);
        load = 1'b1; data = 8'h3C;
        step();
        load = 1'b0;
        chk3("t5.ld", 8'h3C, 1'b0, 1'b0);
        step();
        chk3("t5.after", 8'h3C, 1'b0, 1'b0);

        // 6: async reset mid-burst, then a normal burst
        mode = 2'b00; ser_in = 1'b1; start = 1'b1; shamt = 4'd4;
        step();
        start = 1'b0;
        step();
        chk3("t6.s1", 8'h9E, 1'b1, 1'b0);
        areset = 1'b1;
        #1;
        chk3("t6.rst", 8'h00, 1'b0, 1'b0);
        areset = 1'b0;
        step();
        chk3("t6.idle", 8'h00, 1'b0, 1'b0);
        start = 1'b1; shamt = 4'd2;
        step();
        start = 1'b0;
        step();
        chk3("t6.n1", 8'h80, 1'b1, 1'b0);
        step();
        chk3("t6.n2", 8'hC0, 1'b0, 1'b1);

        // load and start together: load wins
        load = 1'b1; data = 8'h5A; start = 1'b1; shamt = 4'd3;
        step();
        load = 1'b0; start = 1'b0;
        chk3("ls.k", 8'h5A, 1'b0, 1'b0);
        step();
        chk3("ls.after", 8'h5A, 1'b0, 1'b0);

        // shamt >= WIDTH: ror wraps, asr sign-fills, lsr fills
        load = 1'b1; data = 8'h81;
        step();
        load = 1'b0;
        mode = 2'b10; start = 1'b1; shamt = 4'd9;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk3("big.ror", 8'hC0, 1'b0, 1'b1);
        load = 1'b1; data = 8'h80;
        step();
        load = 1'b0;
        mode = 2'b11; start = 1'b1; shamt = 4'd15;
        step();
        start = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk3("big.asr", 8'hFF, 1'b0, 1'b1);
        mode = 2'b00; ser_in = 1'b0; start = 1'b1; shamt = 4'd10;
        step();
        start = 1'b0; ser_in = 1'b1;
        for (int i = 0; i < 2; i++) step();
        ser_in = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk3("big.lsr", 8'h00, 1'b0, 1'b1);
        mode = 2'b01;
        chk("lsl.ser_out", 32'(ser_out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
